// File: rtl/pe_flit_injector.sv
// PE-side packet injector for one CONNECT send port. It splits each request
// into flits, sends a flit only when the downstream VC has credit, takes back
// returned credits, and keeps packet and stall counters for the NoC monitor.
module pe_flit_injector #(
    parameter int unsigned NUM_VCS           = 2,
    parameter int unsigned VC_BITS           = 1,
    parameter int unsigned DEST_BITS         = 4,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned FLIT_BUFFER_DEPTH = 8,
    parameter int unsigned LEN_BITS          = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic [DEST_BITS-1:0]                       req_dest,
    input  logic [VC_BITS-1:0]                         req_vc,
    input  logic [LEN_BITS-1:0]                        req_len,
    input  logic [DATA_WIDTH-1:0]                      req_data,
    output logic [2+DEST_BITS+VC_BITS+DATA_WIDTH-1:0]  flit_out,
    output logic                                       send_flit,
    input  logic [VC_BITS:0]                           credit_in,
    output logic                                       en_recv_credit,
    output logic [15:0]                                pkts_sent,
    output logic [15:0]                                stall_cycles,
    output logic                                       err_credit_ovf
);

    localparam int unsigned CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    // Network flit layout, valid in the MSB.
    typedef struct packed {
        logic                  valid;
        logic                  tail;
        logic [DEST_BITS-1:0]  dest;
        logic [VC_BITS-1:0]    vc;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    logic [0:0]                       state_q, state_d;
    logic [DEST_BITS-1:0]             dest_q, dest_d;
    logic [VC_BITS-1:0]               vc_q, vc_d;
    logic [LEN_BITS-1:0]              len_q, len_d;
    logic [DATA_WIDTH-1:0]            data_q, data_d;
    logic [LEN_BITS-1:0]              idx_q, idx_d;
    flit_t                            flit_q, flit_d;
    logic                             send_flit_q, send_flit_d;
    logic                             req_ready_q, req_ready_d;
    logic                             en_recv_credit_q, en_recv_credit_d;
    logic [15:0]                      pkts_q, pkts_d;
    logic [15:0]                      stall_q, stall_d;
    logic                             ovf_q, ovf_d;
    logic [NUM_VCS-1:0][CNT_W-1:0]    credit_q, credit_d;

    logic [NUM_VCS-1:0]               dec_vec;
    logic [NUM_VCS-1:0]               inc_vec;
    logic                             is_tail;
    logic                             has_credit;

    // Current flit position and credit availability on the active VC.
    always_comb begin
        is_tail    = (idx_q == (len_q - LEN_BITS'(1)));
        has_credit = (credit_q[vc_q] != '0);
    end

    // Packet FSM: request capture, flit generation and status counters.
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        vc_d        = vc_q;
        len_d       = len_q;
        data_d      = data_q;
        idx_d       = idx_q;
        flit_d      = '0;
        send_flit_d = 1'b0;
        pkts_d      = pkts_q;
        stall_d     = stall_q;
        dec_vec     = '0;

        case (state_q)
            S_IDLE: begin
                // A zero-length request carries nothing and is dropped.
                if (req_valid && req_ready_q && (req_len != '0)) begin
                    dest_d  = req_dest;
                    vc_d    = req_vc;
                    len_d   = req_len;
                    data_d  = req_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (has_credit) begin
                    flit_d.valid     = 1'b1;
                    flit_d.tail      = is_tail;
                    flit_d.dest      = dest_q;
                    flit_d.vc        = vc_q;
                    flit_d.data      = data_q + DATA_WIDTH'(idx_q);
                    send_flit_d      = 1'b1;
                    dec_vec[vc_q]    = 1'b1;
                    idx_d            = idx_q + LEN_BITS'(1);
                    if (is_tail) begin
                        pkts_d  = pkts_q + 16'd1;
                        state_d = S_IDLE;
                    end
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d      = (state_d == S_IDLE);
        en_recv_credit_d = 1'b1;
    end

    // Decode the returned-credit bus into a per-VC increment.
    always_comb begin
        inc_vec = '0;
        if (credit_in[VC_BITS]) begin
            inc_vec[credit_in[VC_BITS-1:0]] = 1'b1;
        end
    end

    // Per-VC credit counters; a full counter rejects returns and flags overflow.
    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (inc_vec[v] && !dec_vec[v]) begin
                if (credit_q[v] == CNT_W'(FLIT_BUFFER_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CNT_W'(1);
                end
            end else if (dec_vec[v] && !inc_vec[v]) begin
                credit_d[v] = credit_q[v] - CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dest_q           <= '0;
            vc_q             <= '0;
            len_q            <= '0;
            data_q           <= '0;
            idx_q            <= '0;
            flit_q           <= '0;
            send_flit_q      <= 1'b0;
            req_ready_q      <= 1'b0;
            en_recv_credit_q <= 1'b0;
            pkts_q           <= '0;
            stall_q          <= '0;
            ovf_q            <= 1'b0;
            credit_q         <= {NUM_VCS{CNT_W'(FLIT_BUFFER_DEPTH)}};
        end else begin
            state_q          <= state_d;
            dest_q           <= dest_d;
            vc_q             <= vc_d;
            len_q            <= len_d;
            data_q           <= data_d;
            idx_q            <= idx_d;
            flit_q           <= flit_d;
            send_flit_q      <= send_flit_d;
            req_ready_q      <= req_ready_d;
            en_recv_credit_q <= en_recv_credit_d;
            pkts_q           <= pkts_d;
            stall_q          <= stall_d;
            ovf_q            <= ovf_d;
            credit_q         <= credit_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign flit_out       = flit_q;
    assign send_flit      = send_flit_q;
    assign en_recv_credit = en_recv_credit_q;
    assign pkts_sent      = pkts_q;
    assign stall_cycles   = stall_q;
    assign err_credit_ovf = ovf_q;

endmodule

// File: tb/tb_pe_flit_injector.sv
// Directed bench for pe_flit_injector: a per-cycle vector table plus
// hand-written credit-exhaustion and reset-mid-packet sequences.
module tb_pe_flit_injector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_dest = '0;
    logic [0:0]  req_vc = '0;
    logic [3:0]  req_len = '0;
    logic [31:0] req_data = '0;
    logic [38:0] flit_out;
    logic        send_flit;
    logic [1:0]  credit_in = '0;
    logic        en_recv_credit;
    logic [15:0] pkts_sent;
    logic [15:0] stall_cycles;
    logic        err_credit_ovf;

    int n_cmp = 0;
    int n_err = 0;

    pe_flit_injector dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest       (req_dest),
        .req_vc         (req_vc),
        .req_len        (req_len),
        .req_data       (req_data),
        .flit_out       (flit_out),
        .send_flit      (send_flit),
        .credit_in      (credit_in),
        .en_recv_credit (en_recv_credit),
        .pkts_sent      (pkts_sent),
        .stall_cycles   (stall_cycles),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [3:0]  dest;
        logic        vc;
        logic [3:0]  len;
        logic [31:0] data;
        logic [1:0]  cr;
        logic        e_send;
        logic [38:0] e_flit;
        logic        e_ready;
        logic [15:0] e_pkts;
        logic [15:0] e_stall;
        logic        e_ovf;
        logic        e_en;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic logic [38:0] fl(input logic t, input logic [3:0] d,
                                       input logic v, input logic [31:0] x);
        return {1'b1, t, d, v, x};
    endfunction

    function automatic vec_t mk(input logic r, input logic rv, input logic [3:0] d,
                                input logic v, input logic [3:0] l, input logic [31:0] x,
                                input logic [1:0] c, input logic es, input logic [38:0] ef,
                                input logic er, input logic [15:0] ep, input logic [15:0] est,
                                input logic eo, input logic ee);
        vec_t t;
        t = '{r, rv, d, v, l, x, c, es, ef, er, ep, est, eo, ee};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic req(input logic v, input logic [3:0] d, input logic c,
                       input logic [3:0] l, input logic [31:0] x);
        req_valid = v;
        req_dest  = d;
        req_vc    = c;
        req_len   = l;
        req_data  = x;
    endtask

    initial begin
        logic [31:0] base;

        // rst rv dest vc len data cr | send flit ready pkts stall ovf en
        vecs[0]  = mk(1,0,0,0,0,32'h0,2'b00, 0,39'h0,0,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,0,32'h0,2'b00, 0,39'h0,1,0,0,0,1);
        vecs[2]  = mk(0,1,3,0,4,32'h100,2'b00, 0,39'h0,0,0,0,0,1);
        vecs[3]  = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,3,0,32'h100),0,0,0,0,1);
        vecs[4]  = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,3,0,32'h101),0,0,0,0,1);
        vecs[5]  = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,3,0,32'h102),0,0,0,0,1);
        vecs[6]  = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(1,3,0,32'h103),1,1,0,0,1);
        vecs[7]  = mk(0,1,3,0,0,32'h999,2'b00, 0,39'h0,1,1,0,0,1);
        vecs[8]  = mk(0,1,5,0,3,32'h200,2'b00, 0,39'h0,0,1,0,0,1);
        vecs[9]  = mk(0,0,0,0,0,32'h0,2'b10, 1,fl(0,5,0,32'h200),0,1,0,0,1);
        vecs[10] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,5,0,32'h201),0,1,0,0,1);
        vecs[11] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(1,5,0,32'h202),1,2,0,0,1);
        vecs[12] = mk(0,1,1,0,3,32'h300,2'b00, 0,39'h0,0,2,0,0,1);
        vecs[13] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,1,0,32'h300),0,2,0,0,1);
        vecs[14] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(0,1,0,32'h301),0,2,0,0,1);
        vecs[15] = mk(0,0,0,0,0,32'h0,2'b00, 0,39'h0,0,2,1,0,1);
        vecs[16] = mk(0,0,0,0,0,32'h0,2'b00, 0,39'h0,0,2,2,0,1);
        vecs[17] = mk(0,0,0,0,0,32'h0,2'b10, 0,39'h0,0,2,3,0,1);
        vecs[18] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(1,1,0,32'h302),1,3,3,0,1);
        vecs[19] = mk(0,0,0,0,0,32'h0,2'b11, 0,39'h0,1,3,3,1,1);
        vecs[20] = mk(0,0,0,0,0,32'h0,2'b00, 0,39'h0,1,3,3,1,1);
        vecs[21] = mk(0,1,2,1,1,32'h400,2'b00, 0,39'h0,0,3,3,1,1);
        vecs[22] = mk(0,1,2,1,1,32'h500,2'b00, 1,fl(1,2,1,32'h400),1,4,3,1,1);
        vecs[23] = mk(0,1,2,1,1,32'h500,2'b00, 0,39'h0,0,4,3,1,1);
        vecs[24] = mk(0,0,0,0,0,32'h0,2'b00, 1,fl(1,2,1,32'h500),1,5,3,1,1);

        // Table: inputs applied before an edge, outputs checked just after it.
        for (int i = 0; i < NV; i++) begin
            rst       = vecs[i].rst;
            credit_in = vecs[i].cr;
            req(vecs[i].rv, vecs[i].dest, vecs[i].vc, vecs[i].len, vecs[i].data);
            tick();
            chk($sformatf("row%0d send", i),  64'(send_flit),      64'(vecs[i].e_send));
            chk($sformatf("row%0d flit", i),  64'(flit_out),       64'(vecs[i].e_flit));
            chk($sformatf("row%0d ready", i), 64'(req_ready),      64'(vecs[i].e_ready));
            chk($sformatf("row%0d pkts", i),  64'(pkts_sent),      64'(vecs[i].e_pkts));
            chk($sformatf("row%0d stall", i), 64'(stall_cycles),   64'(vecs[i].e_stall));
            chk($sformatf("row%0d ovf", i),   64'(err_credit_ovf), 64'(vecs[i].e_ovf));
            chk($sformatf("row%0d en", i),    64'(en_recv_credit), 64'(vecs[i].e_en));
        end
        req(0, 0, 0, 0, 0);
        credit_in = 2'b00;

        // Credit exhaustion on vc1 with payload wrapping past 2^32.
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        chk("exh ovf cleared", 64'(err_credit_ovf), 64'd0);
        base = 32'hFFFF_FFFC;
        req(1, 7, 1, 10, base); tick();
        req(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("exh flit%0d send", i), 64'(send_flit), 64'd1);
            chk($sformatf("exh flit%0d", i), 64'(flit_out), 64'(fl(0, 7, 1, base + 32'(i))));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("exh stall%0d send", i), 64'(send_flit), 64'd0);
            chk($sformatf("exh stall%0d flit", i), 64'(flit_out), 64'd0);
        end
        chk("exh stall count", 64'(stall_cycles), 64'd3);
        credit_in = 2'b11; tick(); credit_in = 2'b00;
        chk("exh credit edge send", 64'(send_flit), 64'd0);
        chk("exh credit edge stall", 64'(stall_cycles), 64'd4);
        tick();
        chk("exh flit8 send", 64'(send_flit), 64'd1);
        chk("exh flit8", 64'(flit_out), 64'(fl(0, 7, 1, base + 32'd8)));
        tick();
        chk("exh after8 send", 64'(send_flit), 64'd0);
        chk("exh after8 stall", 64'(stall_cycles), 64'd5);
        credit_in = 2'b11; tick(); credit_in = 2'b00;
        chk("exh credit2 stall", 64'(stall_cycles), 64'd6);
        tick();
        chk("exh tail", 64'(flit_out), 64'(fl(1, 7, 1, base + 32'd9)));
        chk("exh pkts", 64'(pkts_sent), 64'd1);
        chk("exh ready", 64'(req_ready), 64'd1);
        tick();
        chk("exh idle send", 64'(send_flit), 64'd0);
        chk("exh final stall", 64'(stall_cycles), 64'd6);

        // Reset in the middle of a packet, then prove all vc0 credits returned.
        req(1, 9, 0, 6, 32'h700); tick();
        req(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rmid flit1", 64'(flit_out), 64'(fl(0, 9, 0, 32'h701)));
        rst = 1'b1; tick();
        chk("rmid send", 64'(send_flit), 64'd0);
        chk("rmid flit", 64'(flit_out), 64'd0);
        chk("rmid pkts", 64'(pkts_sent), 64'd0);
        chk("rmid ready low", 64'(req_ready), 64'd0);
        rst = 1'b0; tick();
        chk("rmid ready", 64'(req_ready), 64'd1);
        chk("rmid send idle", 64'(send_flit), 64'd0);
        req(1, 2, 0, 9, 32'h800); tick();
        req(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rmid full flit%0d", i), 64'(flit_out), 64'(fl(0, 2, 0, 32'h800 + 32'(i))));
        end
        tick();
        chk("rmid ninth stalls", 64'(send_flit), 64'd0);
        chk("rmid stall", 64'(stall_cycles), 64'd1);
        chk("rmid pkts0", 64'(pkts_sent), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
